// File: rtl/bram_pkg.sv
// bram_pkg: shared widths and request/response records for the 256x64 block RAM
package bram_pkg;
   localparam int BRAM_AW    = 8;
   localparam int BRAM_DW    = 64;
   localparam int BRAM_WORDS = 256;
   typedef struct packed {
      logic [BRAM_AW-1:0] addr;
      logic [BRAM_DW-1:0] wdata;
      logic               wen;
   } bram_req_t;
   typedef struct packed {
      logic [BRAM_DW-1:0] rdata;
      logic [BRAM_AW-1:0] addr;
      logic               wen;
   } bram_resp_t;
endpackage

// File: rtl/bram_sp_256_64.sv
// bram_sp_256_64: single-port READ_FIRST RAM with registered read, contents never reset
module bram_sp_256_64
   import bram_pkg::*;
(
   input  logic               clock,
   input  logic [BRAM_AW-1:0] addr,
   input  logic [BRAM_DW-1:0] wdata,
   input  logic               wen,
   output logic [BRAM_DW-1:0] rdata
);
   logic [BRAM_DW-1:0] mem [BRAM_WORDS];
   always_ff @(posedge clock) begin
      rdata <= mem[addr];
      if (wen) mem[addr] <= wdata;
   end
endmodule

// File: rtl/bram_resp_256_64.sv
// bram_resp_256_64: valid/ready responder front end for the 256x64 RAM with an in-order response FIFO
module bram_resp_256_64
   import bram_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = BRAM_AW,
   parameter int DW    = BRAM_DW
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic          req_wen,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [DW-1:0] resp_rdata,
   output logic [AW-1:0] resp_addr,
   output logic          resp_wen
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic          fire, push, pop, inflight, infl_wen;
   logic [AW-1:0] infl_addr;
   logic [DW-1:0] ram_rdata;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   bram_resp_t    fifo [DEPTH];
   bram_resp_t    head;
   // Reserving a slot for the in-flight read keeps the FIFO from ever overflowing.
   assign req_ready  = !reset && ((CW+1)'(count) + (CW+1)'(inflight) < (CW+1)'(DEPTH));
   assign fire       = req_valid & req_ready;
   assign push       = inflight;
   assign resp_valid = count != '0;
   assign pop        = resp_valid & resp_ready;
   assign head       = fifo[rd_ptr];
   assign resp_rdata = resp_valid ? head.rdata : '0;
   assign resp_addr  = resp_valid ? head.addr : '0;
   assign resp_wen   = resp_valid ? head.wen : 1'b0;
   bram_sp_256_64 u_ram (
      .clock (clock),
      .addr  (req_addr),
      .wdata (req_wdata),
      .wen   (fire & req_wen),
      .rdata (ram_rdata)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         inflight <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         inflight <= fire;
         count    <= count + CW'(push) - CW'(pop);
         if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge clock) begin
      if (fire) begin
         infl_addr <= req_addr;
         infl_wen  <= req_wen;
      end
      if (push) fifo[wr_ptr] <= '{rdata: ram_rdata, addr: infl_addr, wen: infl_wen};
   end
endmodule

// File: tb/tb_bram_resp_256_64.sv
// tb_bram_resp_256_64: directed and random scoreboard bench for the RAM responder
module tb_bram_resp_256_64;
   import bram_pkg::*;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [7:0]  req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        req_wen = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [63:0] resp_rdata;
   logic [7:0]  resp_addr;
   logic        resp_wen;

   always #5 clock = ~clock;

   bram_resp_256_64 dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wen    (req_wen),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_addr  (resp_addr),
      .resp_wen   (resp_wen)
   );

   typedef struct {
      logic [63:0] rdata;
      bit          known;
      logic [7:0]  addr;
      logic        wen;
      int          fired;
      bit          lat;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   logic [63:0] ref_mem [256];
   bit          known [256];
   int          total = 0, bad = 0, cyc = 0, fires = 0, pops = 0;
   bit          lat_chk = 0, stream = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Decide at the falling edge what the coming rising edge will pop and accept.
   always @(negedge clock) begin
      if (reset) q.delete();
      else begin
         if (resp_valid && resp_ready) begin
            pops++;
            chk("resp_expected", 64'(q.size() == 0), 64'd0);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("resp_addr", 64'(resp_addr), 64'(e.addr));
               chk("resp_wen", 64'(resp_wen), 64'(e.wen));
               if (e.known) chk("resp_rdata", resp_rdata, e.rdata);
               if (e.lat) chk("latency", 64'(cyc - e.fired), 64'd2);
            end
         end
         if (req_valid && req_ready) begin
            fires++;
            q.push_back('{rdata: ref_mem[req_addr], known: known[req_addr], addr: req_addr,
                          wen: req_wen, fired: cyc, lat: lat_chk});
            if (req_wen) begin
               ref_mem[req_addr] = req_wdata;
               known[req_addr]   = 1'b1;
            end
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [63:0] d, input logic w);
      int   n = 0;
      logic got;
      req_valid = 1'b1;
      req_addr  = a;
      req_wdata = d;
      req_wen   = w;
      do begin
         @(negedge clock);
         got = req_ready;
         @(posedge clock);
         #1;
         n++;
      end while (!got && n < 50);
      chk("send_accept", 64'(got), 64'd1);
      if (stream) chk("stream_ready", 64'(n), 64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() != 0; i++) begin
         @(posedge clock);
         #1;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
      chk("drain_valid", 64'(resp_valid), 64'd0);
   endtask

   initial begin
      int          f0, p0;
      logic [7:0]  h_addr;
      logic [63:0] h_data;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      chk("rst_addr", 64'(resp_addr), 64'd0);
      chk("rst_wen", 64'(resp_wen), 64'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("ready_after_reset", 64'(req_ready), 64'd1);

      // write/readback
      resp_ready = 1'b1;
      lat_chk    = 1'b1;
      for (int i = 0; i < 8; i++) send(8'(i), 64'(i + 'h10), 1'b1);
      for (int i = 0; i < 8; i++) send(8'(i), 64'd0, 1'b0);
      req_valid = 1'b0;
      drain();

      // READ_FIRST on the same word
      send(8'd3, 64'hAAAA, 1'b1);
      send(8'd3, 64'h5555, 1'b1);
      send(8'd3, 64'd0, 1'b0);
      req_valid = 1'b0;
      drain();

      // back-pressure
      lat_chk    = 1'b0;
      resp_ready = 1'b0;
      f0         = fires;
      req_valid  = 1'b1;
      req_wen    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         req_addr = 8'(40 + fires - f0);
         @(posedge clock);
         #1;
      end
      chk("bp_accepted", 64'(fires - f0), 64'd4);
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      chk("bp_valid", 64'(resp_valid), 64'd1);
      h_addr = resp_addr;
      h_data = resp_rdata;
      repeat (3) @(posedge clock);
      #1;
      chk("bp_head_addr", 64'(resp_addr), 64'(h_addr));
      chk("bp_head_data", resp_rdata, h_data);
      req_valid  = 1'b0;
      p0         = pops;
      resp_ready = 1'b1;
      drain();
      chk("bp_pops", 64'(pops - p0), 64'd4);
      chk("bp_ready_back", 64'(req_ready), 64'd1);

      // streaming
      lat_chk = 1'b1;
      stream  = 1'b1;
      for (int i = 0; i < 16; i++) send(8'(i), 64'd0, 1'b0);
      req_valid = 1'b0;
      stream    = 1'b0;
      drain();

      // reset with two queued and one in flight
      for (int i = 0; i < 3; i++) send(8'(8'h20 + i), 64'hC0DE00 + 64'(i), 1'b1);
      req_valid = 1'b0;
      drain();
      lat_chk    = 1'b0;
      resp_ready = 1'b0;
      send(8'h20, 64'd0, 1'b0);
      send(8'h21, 64'd0, 1'b0);
      send(8'h30, 64'hBEEF, 1'b1);
      req_valid = 1'b0;
      reset     = 1'b1;
      @(posedge clock);
      #1;
      chk("midrst_valid", 64'(resp_valid), 64'd0);
      chk("midrst_ready", 64'(req_ready), 64'd0);
      reset      = 1'b0;
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      chk("postrst_valid", 64'(resp_valid), 64'd0);
      for (int i = 0; i < 3; i++) send(8'(8'h20 + i), 64'd0, 1'b0);
      send(8'h30, 64'd0, 1'b0);
      req_valid = 1'b0;
      drain();

      // random traffic against the reference memory
      f0 = fires;
      for (int c = 0; c < 6000 && fires - f0 < 500; c++) begin
         req_valid  = $urandom_range(0, 9) < 7;
         req_addr   = 8'($urandom_range(0, 31));
         req_wen    = 1'($urandom_range(0, 1));
         req_wdata  = {$urandom, $urandom};
         resp_ready = $urandom_range(0, 3) != 0;
         @(posedge clock);
         #1;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      chk("rand_ops", 64'(fires - f0), 64'd500);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
